// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//
// ID/EX pipeline register for a classic five-stage MIPS-style pipeline. It
// carries the decoded instruction from the decode stage into execute, and
// honours the hazard unit's stall (hold) and flush (bubble) requests. It also
// counts the bubbles delivered to EX, saturating at 16'hFFFF.
//
// Per-edge priority: rst > flush > stall > load.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset; clears every output
//   stall          hold all EX-side state (including bubble_cnt)
//   flush          squash: ex_valid/ex_ctrl cleared, data fields held
//   id_valid       decode stage presents a real instruction
//   id_pc4         PC+4 of the decoded instruction
//   id_rd1/id_rd2  register-file read data (rs, rt)
//   id_imm         sign-extended immediate, passed bit-exact
//   id_rs/rt/rd    register specifiers
//   id_ctrl        packed control bundle
//                  {reg_write, mem_to_reg, mem_read, mem_write, branch,
//                   alu_src, reg_dst, alu_op[1:0]}
//   ex_*           registered copies of the id_* fields
//   ex_valid       EX holds a real instruction
//   bubble_cnt     number of bubbles delivered to EX (saturating)
// -----------------------------------------------------------------------------
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [15:0]       bubble_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // A bubble reaches EX on a flush edge, or on a load edge carrying no real
  // instruction. rst outranks both; stall only matters when flush is low.
  logic load_en;
  logic bubble_en;
  logic [15:0] bubble_cnt_inc;

  always_comb begin
    load_en        = !flush && !stall;
    bubble_en      = flush || (load_en && !id_valid);
    bubble_cnt_inc = (bubble_cnt == CNT_MAX) ? CNT_MAX : bubble_cnt + 16'd1;
  end

  // Valid and control: these are the fields a bubble must clear, so they are
  // kept apart from the datapath fields, which a flush leaves untouched.
  // NOTE: every flop here uses non-blocking assignment so all registers sample
  // pre-edge values; blocking assignments would let one stage's update leak
  // into another within the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (load_en) begin
      ex_valid <= id_valid;
      // An invalid slot must not assert write enables or memory strobes
      // downstream, so its control bundle is zeroed even though the data
      // fields are captured as presented.
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

  // Datapath and specifier fields: captured on load, held on stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc4 <= '0;
      ex_rd1 <= '0;
      ex_rd2 <= '0;
      ex_imm <= '0;
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_rd  <= '0;
    end else if (load_en) begin
      ex_pc4 <= id_pc4;
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
    end
  end

  // Saturating bubble counter; frozen on stall edges because bubble_en is low
  // whenever stall holds the register without a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble_en) begin
      bubble_cnt <= bubble_cnt_inc;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
//
// Self-checking bench for id_ex_reg. A behavioural model tracks what EX should
// hold after each rising edge, derived from the rule set: reset clears all,
// flush makes a bubble, stall holds, otherwise load. Directed scenarios cover
// the reset/load/stall/flush/invalid/saturation cases, followed by a long
// randomized stream compared every cycle.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [15:0]       bubble_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_pc4     (id_pc4),
    .id_rd1     (id_rd1),
    .id_rd2     (id_rd2),
    .id_imm     (id_imm),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_ctrl    (id_ctrl),
    .ex_valid   (ex_valid),
    .ex_pc4     (ex_pc4),
    .ex_rd1     (ex_rd1),
    .ex_rd2     (ex_rd2),
    .ex_imm     (ex_imm),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_ctrl    (ex_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  // Expected EX-stage contents.
  typedef struct {
    bit                valid;
    logic [DATA_W-1:0] pc4, rd1, rd2, imm;
    logic [4:0]        rs, rt, rd;
    logic [CTRL_W-1:0] ctrl;
    int                bubbles;
  } ex_model_t;

  ex_model_t m;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      m = '{valid: 0, pc4: 0, rd1: 0, rd2: 0, imm: 0, rs: 0, rt: 0, rd: 0, ctrl: 0, bubbles: 0};
    end else if (flush) begin
      m.valid   = 0;
      m.ctrl    = '0;
      m.bubbles = (m.bubbles + 1 > 65535) ? 65535 : m.bubbles + 1;
    end else if (!stall) begin
      m.valid = id_valid;
      m.pc4   = id_pc4;
      m.rd1   = id_rd1;
      m.rd2   = id_rd2;
      m.imm   = id_imm;
      m.rs    = id_rs;
      m.rt    = id_rt;
      m.rd    = id_rd;
      m.ctrl  = id_valid ? id_ctrl : '0;
      if (!id_valid) m.bubbles = (m.bubbles + 1 > 65535) ? 65535 : m.bubbles + 1;
    end
  endtask

  // One clock: update the model, let the edge happen, sample 1 ns later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"},  64'(ex_valid),   64'(m.valid));
    check({tag, ".pc4"},    64'(ex_pc4),     64'(m.pc4));
    check({tag, ".rd1"},    64'(ex_rd1),     64'(m.rd1));
    check({tag, ".rd2"},    64'(ex_rd2),     64'(m.rd2));
    check({tag, ".imm"},    64'(ex_imm),     64'(m.imm));
    check({tag, ".rs"},     64'(ex_rs),      64'(m.rs));
    check({tag, ".rt"},     64'(ex_rt),      64'(m.rt));
    check({tag, ".rd"},     64'(ex_rd),      64'(m.rd));
    check({tag, ".ctrl"},   64'(ex_ctrl),    64'(m.ctrl));
    check({tag, ".bubble"}, 64'(bubble_cnt), 64'(m.bubbles));
  endtask

  task automatic randomize_id_fields();
    id_pc4  = $urandom;
    id_rd1  = $urandom;
    id_rd2  = $urandom;
    id_imm  = $urandom;
    id_rs   = 5'($urandom);
    id_rt   = 5'($urandom);
    id_rd   = 5'($urandom);
    id_ctrl = CTRL_W'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    randomize_id_fields();
    #2;

    // Reset: every output zero.
    tick();
    compare_all("reset");

    // Reset then load.
    rst = 1'b0;
    randomize_id_fields();
    id_valid = 1'b1; id_imm = 32'hFFFF8000; id_ctrl = 9'h1A3; id_rt = 5'd9;
    tick();
    check("load.valid",  64'(ex_valid),   64'd1);
    check("load.imm",    64'(ex_imm),     64'hFFFF8000);
    check("load.ctrl",   64'(ex_ctrl),    64'h1A3);
    check("load.rt",     64'(ex_rt),      64'd9);
    check("load.bubble", 64'(bubble_cnt), 64'd0);
    compare_all("load");

    // Stall hold for 3 cycles while inputs churn.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_id_fields();
      id_valid = 1'($urandom);
      tick();
      check("stall.imm",  64'(ex_imm),  64'hFFFF8000);
      check("stall.ctrl", 64'(ex_ctrl), 64'h1A3);
      check("stall.rt",   64'(ex_rt),   64'd9);
      compare_all("stall");
    end

    // Release stall: new fields appear one edge later (imm kept for next step).
    stall = 1'b0;
    randomize_id_fields();
    id_valid = 1'b1; id_imm = 32'hFFFF8000; id_rd1 = 32'hCAFE0001;
    tick();
    check("unstall.rd1", 64'(ex_rd1), 64'hCAFE0001);
    compare_all("unstall");

    // Flush with stall acts as flush.
    flush = 1'b1; stall = 1'b1; id_valid = 1'b1;
    randomize_id_fields();
    tick();
    check("flush.valid",  64'(ex_valid),   64'd0);
    check("flush.ctrl",   64'(ex_ctrl),    64'd0);
    check("flush.imm",    64'(ex_imm),     64'hFFFF8000);
    check("flush.bubble", 64'(bubble_cnt), 64'd1);
    compare_all("flush");

    // Invalid load: control zeroed, data captured, bubble counted.
    flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
    randomize_id_fields();
    id_ctrl = 9'h1FF; id_rd1 = 32'h12345678;
    tick();
    check("inval.ctrl",   64'(ex_ctrl),    64'd0);
    check("inval.rd1",    64'(ex_rd1),     64'h12345678);
    check("inval.valid",  64'(ex_valid),   64'd0);
    check("inval.bubble", 64'(bubble_cnt), 64'd2);
    compare_all("inval");

    // Saturation: 65540 consecutive flushes.
    flush = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      stall = 1'($urandom);
      tick();
      if (i == 65530) check("sat.near", 64'(bubble_cnt), 64'(m.bubbles));
    end
    check("sat.max", 64'(bubble_cnt), 64'hFFFF);
    tick();
    check("sat.hold", 64'(bubble_cnt), 64'hFFFF);
    compare_all("sat");
    rst = 1'b1;
    tick();
    check("sat.rst", 64'(bubble_cnt), 64'd0);
    compare_all("sat_rst");

    // Reset mid-stall while EX holds a valid instruction.
    rst = 1'b0; flush = 1'b0; stall = 1'b0; id_valid = 1'b1;
    randomize_id_fields();
    tick();
    check("pre_rst.valid", 64'(ex_valid), 64'd1);
    rst = 1'b1; stall = 1'b1;
    randomize_id_fields();
    tick();
    compare_all("rst_stall");
    // First edge after reset deasserts follows normal priority.
    rst = 1'b0; stall = 1'b0;
    randomize_id_fields();
    tick();
    compare_all("post_rst");

    // Random stream against the model.
    for (int i = 0; i < 10000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      randomize_id_fields();
      tick();
      compare_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the PC+4, register-read and immediate datapaths.
REQ-002 Parameter CTRL_W, default 9, width of the packed control bundle {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  hazard unit hold request; ID/EX contents frozen.
REQ-006 flush  input  1  hazard unit squash request; inserts a bubble into EX.
REQ-007 id_valid  input  1  the decode stage presents a real instruction.
REQ-008 id_pc4  input  DATA_W  PC+4 of the decoded instruction.
REQ-009 id_rd1, id_rd2  input  DATA_W each  register-file read data for rs and rt.
REQ-010 id_imm  input  DATA_W  sign-extended 16-bit immediate from the sign-extension stage.
REQ-011 id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-012 id_ctrl  input  CTRL_W  decoded control bundle.
REQ-013 ex_valid  output  1  EX holds a real instruction.
REQ-014 ex_pc4, ex_rd1, ex_rd2, ex_imm  output  DATA_W each  registered copies of the id_* fields.
REQ-015 ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers.
REQ-016 ex_ctrl  output  CTRL_W  registered control bundle.
REQ-017 bubble_cnt  output  16  count of bubbles delivered to EX.

Function
REQ-018 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-019 Per edge, priority SHALL be rst > flush > stall > load.
REQ-020 Load (no rst/flush/stall) SHALL capture every id_* field into its ex_* register; latency 1 cycle; ex_valid <= id_valid.
REQ-021 Load with id_valid=0 SHALL force ex_ctrl to 0; data and specifier fields are captured normally.
REQ-022 Stall SHALL hold every ex_* register, ex_valid and bubble_cnt unchanged for as many consecutive cycles as stall is asserted.
REQ-023 Flush SHALL set ex_valid=0 and ex_ctrl=0 and hold the data and specifier fields.
REQ-024 Flush and stall asserted together SHALL act as flush.
REQ-025 bubble_cnt SHALL increment by 1 on each edge that performs a flush, or a load with id_valid=0.
REQ-026 bubble_cnt SHALL saturate at 16'hFFFF with no wrap.
REQ-027 bubble_cnt SHALL NOT change on a stall edge.
REQ-028 ex_imm SHALL be passed bit-exact with no re-extension or truncation; sign handling belongs upstream.

Reset
REQ-029 On a rising edge with rst=1, every output, including ex_valid, ex_ctrl, all data fields and bubble_cnt, SHALL become 0 regardless of stall/flush.
REQ-030 rst asserted mid-stall SHALL clear the register; the first edge after rst deasserts SHALL obey REQ-019 normally.
REQ-031 Outputs before the first reset edge are undefined; the bench SHALL NOT check them.

Verification
REQ-032 Reset then load: rst 1 cycle, then id_valid=1, id_imm=32'hFFFF8000, id_ctrl=9'h1A3, id_rt=5'd9 -> next edge ex_valid=1, ex_imm=32'hFFFF8000, ex_ctrl=9'h1A3, ex_rt=9, bubble_cnt=0.
REQ-033 Stall hold: after REQ-032, stall=1 for 3 cycles while id_* change -> outputs unchanged all 3 cycles; stall=0 -> new id_* appear 1 cycle later.
REQ-034 Flush with stall: flush=1, stall=1, id_valid=1 -> ex_valid=0, ex_ctrl=0, ex_imm retains 32'hFFFF8000, bubble_cnt=1.
REQ-035 Invalid load: id_valid=0, id_ctrl=9'h1FF, id_rd1=32'h12345678 -> ex_ctrl=0, ex_rd1=32'h12345678, ex_valid=0, bubble_cnt increments.
REQ-036 Saturation: force 65540 consecutive flush edges -> bubble_cnt reads 16'hFFFF and stays there; one rst edge -> 0.
REQ-037 Reset mid-operation: rst=1 with stall=1 and flush=0 while ex_valid=1 -> all outputs 0 next edge; random stall/flush/id_valid stream for 10k cycles matches a reference model every cycle.
